memwb_pipe_reg: RTL and testbench
=================================

MEMWB_PIPE_REG -- requirements
Module: memwb_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, general-register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register-file address width.
REQ-003 SHALL have parameter BSEL_W, default 4, byte-enable width (DATA_W/8).
REQ-004 SHALL have one clock and an asynchronous, active-low reset:
- cpu_clk_50M  in  1  clock.
- cpu_rst_n  in  1  asynchronous reset, active low.
REQ-005 SHALL have these remaining ports:
- mem_valid  in  1  upstream entry valid.
- mem_ready  out  1  block can accept an entry.
- mem_wa  in  ADDR_W  destination register.
- mem_wreg  in  1  register write enable.
- mem_dreg  in  DATA_W  write-back data.
- mem_mreg  in  1  load-result select.
- mem_dre  in  BSEL_W  load byte enables.
- mem_whilo  in  1  HI/LO write enable.
- mem_hilo  in  2*DATA_W  HI/LO data.
- flush  in  1  synchronous pipeline flush.
- wb_ready  in  1  write-back consumes the entry.
- wb_valid  out  1  output entry valid.
- wb_wa, wb_wreg, wb_dreg, wb_mreg, wb_dre, wb_whilo, wb_hilo  out  as mem_*  registered payload.

Function
REQ-006 SHALL accept an entry on a rising edge where mem_valid && mem_ready && !flush.
REQ-007 SHALL present an accepted entry on wb_* with wb_valid=1 one cycle after acceptance, when the output register is empty or drained in the same cycle.
REQ-008 SHALL hold all wb_* outputs stable while wb_valid && !wb_ready (stall).
REQ-009 SHALL drive wb_wreg, wb_mreg, wb_whilo to 0 whenever wb_valid=0; payload data fields are don't-care but SHALL hold their last value.
REQ-010 SHALL, on flush=1 at an edge, clear wb_valid and every buffered entry, and drop any simultaneous input entry.
REQ-011 SHALL give flush priority over stall, over acceptance and over wb_ready.
REQ-012 SHALL preserve entry order; no entry is duplicated or lost except by flush.
REQ-013 SHALL treat a cycle where mem_valid=0 and the output drains as a bubble: wb_valid=0 next cycle.
REQ-014 SHALL route widths purely by parameter; no truncation between mem_* and wb_*.

Reset
REQ-015 SHALL, while cpu_rst_n=0, asynchronously force:
- wb_valid=0, wb_wreg=0, wb_mreg=0, wb_whilo=0.
- wb_wa=0, wb_dreg=0, wb_dre=0, wb_hilo=0.
- every buffer entry invalid.
REQ-016 SHALL drive mem_ready=1 during reset, but SHALL accept nothing until the first edge after release.
REQ-017 SHALL discard any entry in flight when reset asserts mid-operation.

Configuration
REQ-018 SHALL support macro MEMWB_SKID_EN.
REQ-019 With MEMWB_SKID_EN defined:
- SHALL add a one-entry skid buffer, giving two entries total.
- mem_ready SHALL be a pure register output, equal to !skid_valid.
- An entry arriving while the output is stalled SHALL go to the skid buffer.
- The skid entry SHALL move to the output on the next edge with wb_ready=1.
REQ-020 Without MEMWB_SKID_EN:
- mem_ready SHALL equal !wb_valid || wb_ready (combinational).
- Capacity SHALL be one entry.

Structure
REQ-021 SHALL place default widths, the zero constants and the packed payload typedef (wa, wreg, dreg, mreg, dre, whilo, hilo) in the shared package pipe_pkg.
REQ-022 SHALL implement storage with one sub-module, pipe_slot: a single valid+payload register with load, hold and clear. Instantiate it once, or twice with MEMWB_SKID_EN.

Verification
REQ-023 Reset test: assert cpu_rst_n=0 mid-transfer -> wb_valid=0, wb_wreg=0, wb_hilo=0 immediately, without waiting for a clock edge.
REQ-024 Pass-through test: wb_ready=1; issue mem_wa=5'd3, mem_dreg=32'hDEAD_BEEF, mem_wreg=1 with mem_valid=1 -> exactly one cycle later wb_wa=3, wb_dreg=DEADBEEF, wb_valid=1.
REQ-025 Stall test: wb_ready=0 for 3 cycles with entry A at the output -> wb_* equal A for all 3 cycles. With MEMWB_SKID_EN, entry B is accepted and mem_ready falls the next cycle; B appears one cycle after wb_ready returns to 1.
REQ-026 Flush test: flush=1 with mem_valid=1 and wb_valid=1 -> next cycle wb_valid=0, wb_wreg=0, wb_whilo=0, and the skid buffer is empty.
REQ-027 Bubble test: mem_valid=0 for one cycle -> wb_valid=0 and wb_wreg=0 for exactly one cycle, with no register-file write.
REQ-028 Width test: DATA_W=64, BSEL_W=8 -> mem_hilo=128'h1 propagates bit-exact to wb_hilo.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, zero constants and MEM/WB payload layout for the pipeline registers.
package pipe_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_BSEL_W = 4;

    // Field order is the packing order used when flattening a payload into a slot.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]   wa;
        logic                    wreg;
        logic [DEF_DATA_W-1:0]   dreg;
        logic                    mreg;
        logic [DEF_BSEL_W-1:0]   dre;
        logic                    whilo;
        logic [2*DEF_DATA_W-1:0] hilo;
    } memwb_payload_t;

    localparam logic [DEF_DATA_W-1:0]   ZERO_DATA    = '0;
    localparam logic [2*DEF_DATA_W-1:0] ZERO_HILO    = '0;
    localparam memwb_payload_t          PAYLOAD_ZERO = '0;

endpackage

// File: rtl/pipe_slot.sv
// Single valid+payload register with clear > load > drain priority.
// Bits set in CLR_MASK are zeroed whenever the slot goes empty; the rest hold.
module pipe_slot #(
    parameter int unsigned     W        = 8,
    parameter logic [W-1:0]    CLR_MASK = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         drain,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Slot state update; emptying the slot kills the masked control bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= q & ~CLR_MASK;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (drain) begin
            valid <= 1'b0;
            q     <= q & ~CLR_MASK;
        end
    end

endmodule

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake and synchronous flush.
// Optional macro MEMWB_SKID_EN adds a one-entry skid slot so mem_ready is registered.
module memwb_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned BSEL_W = DEF_BSEL_W
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst_n,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_wa,
    input  logic                mem_wreg,
    input  logic [DATA_W-1:0]   mem_dreg,
    input  logic                mem_mreg,
    input  logic [BSEL_W-1:0]   mem_dre,
    input  logic                mem_whilo,
    input  logic [2*DATA_W-1:0] mem_hilo,
    input  logic                flush,
    input  logic                wb_ready,
    output logic                wb_valid,
    output logic [ADDR_W-1:0]   wb_wa,
    output logic                wb_wreg,
    output logic [DATA_W-1:0]   wb_dreg,
    output logic                wb_mreg,
    output logic [BSEL_W-1:0]   wb_dre,
    output logic                wb_whilo,
    output logic [2*DATA_W-1:0] wb_hilo
);

    localparam int unsigned PAY_W = ADDR_W + DATA_W + BSEL_W + 2*DATA_W + 3;

    // wreg, mreg and whilo must read 0 whenever the slot is empty.
    localparam logic [PAY_W-1:0] CTRL_MASK = {
        {ADDR_W{1'b0}}, 1'b1, {DATA_W{1'b0}}, 1'b1,
        {BSEL_W{1'b0}}, 1'b1, {(2*DATA_W){1'b0}}
    };

    logic [PAY_W-1:0] mem_pay;
    logic [PAY_W-1:0] out_pay;
    logic             out_valid;
    logic             out_free;
    logic             accept;

    assign mem_pay  = {mem_wa, mem_wreg, mem_dreg, mem_mreg, mem_dre, mem_whilo, mem_hilo};
    assign out_free = !out_valid || wb_ready;
    assign accept   = mem_valid && mem_ready && !flush;

`ifdef MEMWB_SKID_EN
    logic             skid_valid;
    logic [PAY_W-1:0] skid_pay;
    logic             out_load;
    logic [PAY_W-1:0] out_d;
    logic             skid_load;
    logic             skid_drain;

    assign mem_ready = !skid_valid;

    // Steering: the skid entry is older, so it always wins the output slot.
    always_comb begin
        out_load   = 1'b0;
        out_d      = mem_pay;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        if (out_free) begin
            out_load   = skid_valid || accept;
            out_d      = skid_valid ? skid_pay : mem_pay;
            skid_drain = skid_valid;
        end else begin
            skid_load  = accept;
        end
    end

    pipe_slot #(.W(PAY_W), .CLR_MASK(CTRL_MASK)) u_skid (
        .clk   (cpu_clk_50M),
        .rst_n (cpu_rst_n),
        .load  (skid_load),
        .drain (skid_drain),
        .clear (flush),
        .d     (mem_pay),
        .valid (skid_valid),
        .q     (skid_pay)
    );

    pipe_slot #(.W(PAY_W), .CLR_MASK(CTRL_MASK)) u_out (
        .clk   (cpu_clk_50M),
        .rst_n (cpu_rst_n),
        .load  (out_load),
        .drain (out_valid && wb_ready),
        .clear (flush),
        .d     (out_d),
        .valid (out_valid),
        .q     (out_pay)
    );
`else
    assign mem_ready = out_free;

    pipe_slot #(.W(PAY_W), .CLR_MASK(CTRL_MASK)) u_out (
        .clk   (cpu_clk_50M),
        .rst_n (cpu_rst_n),
        .load  (accept),
        .drain (out_valid && wb_ready),
        .clear (flush),
        .d     (mem_pay),
        .valid (out_valid),
        .q     (out_pay)
    );
`endif

    assign wb_valid = out_valid;
    assign {wb_wa, wb_wreg, wb_dreg, wb_mreg, wb_dre, wb_whilo, wb_hilo} = out_pay;

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Self-checking bench for memwb_pipe_reg (default widths plus a 64-bit instance).
module tb_memwb_pipe_reg;
    import pipe_pkg::*;

    logic cpu_clk_50M = 1'b0;
    always #10 cpu_clk_50M = ~cpu_clk_50M;

    logic         cpu_rst_n;
    logic         mem_valid, mem_ready, flush, wb_ready, wb_valid;
    logic [4:0]   mem_wa, wb_wa;
    logic         mem_wreg, wb_wreg, mem_mreg, wb_mreg, mem_whilo, wb_whilo;
    logic [31:0]  mem_dreg, wb_dreg;
    logic [3:0]   mem_dre, wb_dre;
    logic [63:0]  mem_hilo, wb_hilo;

    logic         w_mem_valid, w_mem_ready, w_wb_ready, w_wb_valid;
    logic [4:0]   w_mem_wa, w_wb_wa;
    logic         w_mem_wreg, w_wb_wreg, w_mem_mreg, w_wb_mreg, w_mem_whilo, w_wb_whilo;
    logic [63:0]  w_mem_dreg, w_wb_dreg;
    logic [7:0]   w_mem_dre, w_wb_dre;
    logic [127:0] w_mem_hilo, w_wb_hilo;

    memwb_payload_t wb_obs;
    memwb_payload_t exp_q[$];
    memwb_payload_t exp_e, cur;
    int checks   = 0;
    int failures = 0;

    assign wb_obs = {wb_wa, wb_wreg, wb_dreg, wb_mreg, wb_dre, wb_whilo, wb_hilo};

    memwb_pipe_reg u_dut (
        .cpu_clk_50M (cpu_clk_50M), .cpu_rst_n (cpu_rst_n),
        .mem_valid (mem_valid), .mem_ready (mem_ready),
        .mem_wa (mem_wa), .mem_wreg (mem_wreg), .mem_dreg (mem_dreg),
        .mem_mreg (mem_mreg), .mem_dre (mem_dre), .mem_whilo (mem_whilo),
        .mem_hilo (mem_hilo), .flush (flush), .wb_ready (wb_ready),
        .wb_valid (wb_valid), .wb_wa (wb_wa), .wb_wreg (wb_wreg),
        .wb_dreg (wb_dreg), .wb_mreg (wb_mreg), .wb_dre (wb_dre),
        .wb_whilo (wb_whilo), .wb_hilo (wb_hilo)
    );

    memwb_pipe_reg #(.DATA_W(64), .ADDR_W(5), .BSEL_W(8)) u_wide (
        .cpu_clk_50M (cpu_clk_50M), .cpu_rst_n (cpu_rst_n),
        .mem_valid (w_mem_valid), .mem_ready (w_mem_ready),
        .mem_wa (w_mem_wa), .mem_wreg (w_mem_wreg), .mem_dreg (w_mem_dreg),
        .mem_mreg (w_mem_mreg), .mem_dre (w_mem_dre), .mem_whilo (w_mem_whilo),
        .mem_hilo (w_mem_hilo), .flush (1'b0), .wb_ready (w_wb_ready),
        .wb_valid (w_wb_valid), .wb_wa (w_wb_wa), .wb_wreg (w_wb_wreg),
        .wb_dreg (w_wb_dreg), .wb_mreg (w_wb_mreg), .wb_dre (w_wb_dre),
        .wb_whilo (w_wb_whilo), .wb_hilo (w_wb_hilo)
    );

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic drive_entry(input memwb_payload_t p);
        mem_valid = 1'b1;
        {mem_wa, mem_wreg, mem_dreg, mem_mreg, mem_dre, mem_whilo, mem_hilo} = p;
    endtask

    function automatic memwb_payload_t rand_entry();
        memwb_payload_t p;
        p.wa    = 5'($urandom);
        p.wreg  = 1'b1;
        p.dreg  = $urandom;
        p.mreg  = 1'($urandom);
        p.dre   = 4'($urandom);
        p.whilo = 1'b1;
        p.hilo  = {$urandom, $urandom};
        return p;
    endfunction

    task automatic test_reset();
        memwb_payload_t x;
        cpu_rst_n = 1'b0;
        flush     = 1'b0;
        wb_ready  = 1'b1;
        drive_entry(rand_entry());
        tick();
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", wb_valid); end
        checks++; if (wb_obs !== PAYLOAD_ZERO) begin failures++; $display("FAIL rst_payload: got %h want 0", wb_obs); end
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", mem_ready); end
        mem_valid = 1'b0;
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_no_accept: got %b want 0", wb_valid); end
        // Reset asserted between edges while an entry sits on the output.
        x = rand_entry();
        wb_ready = 1'b0;
        drive_entry(x);
        tick();
        mem_valid = 1'b0;
        checks++; if (wb_obs !== x || wb_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_load: got %h want %h", wb_obs, x); end
        #5;
        cpu_rst_n = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0 || wb_wreg !== 1'b0 || wb_hilo !== ZERO_HILO) begin
            failures++; $display("FAIL rst_async: valid=%b wreg=%b hilo=%h want 0", wb_valid, wb_wreg, wb_hilo); end
        exp_q.delete();
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        wb_ready  = 1'b1;
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_after: got %b want 0", wb_valid); end
    endtask

    task automatic test_pass_through();
        memwb_payload_t p;
        p = '{wa: 5'd3, wreg: 1'b1, dreg: 32'hDEAD_BEEF, mreg: 1'b0, dre: 4'hF,
              whilo: 1'b1, hilo: 64'h0123_4567_89AB_CDEF};
        wb_ready = 1'b1;
        drive_entry(p);
        exp_q.push_back(p);
        tick();
        mem_valid = 1'b0;
        exp_e = exp_q.pop_front();
        checks++; if (wb_valid !== 1'b1 || wb_obs !== exp_e) begin
            failures++; $display("FAIL pass_data: valid=%b got %h want %h", wb_valid, wb_obs, exp_e); end
        tick();
        checks++; if (wb_valid !== 1'b0 || wb_wreg !== 1'b0 || wb_whilo !== 1'b0 || wb_mreg !== 1'b0) begin
            failures++; $display("FAIL pass_empty: valid=%b wreg=%b whilo=%b", wb_valid, wb_wreg, wb_whilo); end
        checks++; if (wb_dreg !== 32'hDEAD_BEEF || wb_wa !== 5'd3) begin
            failures++; $display("FAIL pass_hold: dreg=%h wa=%0d want DEADBEEF/3", wb_dreg, wb_wa); end
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            memwb_payload_t e;
            e = rand_entry();
            drive_entry(e);
            exp_q.push_back(e);
            tick();
            exp_e = exp_q.pop_front();
            checks++; if (wb_valid !== 1'b1 || wb_obs !== exp_e) begin
                failures++; $display("FAIL b2b_%0d: valid=%b got %h want %h", i, wb_valid, wb_obs, exp_e); end
        end
        mem_valid = 1'b0;
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL b2b_end: got %b want 0", wb_valid); end
    endtask

    task automatic test_bubble();
        memwb_payload_t e1, e2;
        e1 = rand_entry();
        e2 = rand_entry();
        wb_ready = 1'b1;
        drive_entry(e1);
        exp_q.push_back(e1);
        tick();
        mem_valid = 1'b0;
        exp_e = exp_q.pop_front();
        checks++; if (wb_valid !== 1'b1 || wb_obs !== exp_e) begin failures++; $display("FAIL bub_e1: got %h want %h", wb_obs, exp_e); end
        tick();
        checks++; if (wb_valid !== 1'b0 || wb_wreg !== 1'b0) begin
            failures++; $display("FAIL bub_gap: valid=%b wreg=%b want 0/0", wb_valid, wb_wreg); end
        drive_entry(e2);
        exp_q.push_back(e2);
        tick();
        mem_valid = 1'b0;
        exp_e = exp_q.pop_front();
        checks++; if (wb_valid !== 1'b1 || wb_obs !== exp_e) begin failures++; $display("FAIL bub_e2: got %h want %h", wb_obs, exp_e); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL bub_tail: got %b want 0", wb_valid); end
    endtask

    task automatic test_stall();
        memwb_payload_t a, b;
        logic want_ready;
        a = rand_entry();
        b = rand_entry();
        wb_ready = 1'b1;
        drive_entry(a);
        exp_q.push_back(a);
        tick();
        cur = exp_q.pop_front();
        checks++; if (wb_valid !== 1'b1 || wb_obs !== cur) begin failures++; $display("FAIL stall_a: got %h want %h", wb_obs, cur); end
        wb_ready = 1'b0;
        drive_entry(b);
        exp_q.push_back(b);
        #1;
`ifdef MEMWB_SKID_EN
        want_ready = 1'b1;
`else
        want_ready = 1'b0;
`endif
        checks++; if (mem_ready !== want_ready) begin failures++; $display("FAIL stall_ready0: got %b want %b", mem_ready, want_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
`ifdef MEMWB_SKID_EN
            mem_valid = 1'b0;
`endif
            checks++; if (wb_valid !== 1'b1 || wb_obs !== cur) begin
                failures++; $display("FAIL stall_hold_%0d: got %h want %h", k, wb_obs, cur); end
            checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_%0d: got %b want 0", k, mem_ready); end
        end
        wb_ready = 1'b1;
        tick();
        mem_valid = 1'b0;
        exp_e = exp_q.pop_front();
        checks++; if (wb_valid !== 1'b1 || wb_obs !== exp_e) begin failures++; $display("FAIL stall_b: got %h want %h", wb_obs, exp_e); end
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_end: got %b want 1", mem_ready); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL stall_tail: got %b want 0", wb_valid); end
    endtask

    task automatic test_flush();
        memwb_payload_t a, b, c;
        a = rand_entry();
        b = rand_entry();
        c = rand_entry();
        wb_ready = 1'b1;
        drive_entry(a);
        exp_q.push_back(a);
        tick();
        exp_e = exp_q.pop_front();
        checks++; if (wb_valid !== 1'b1 || wb_obs !== exp_e) begin failures++; $display("FAIL flush_a: got %h want %h", wb_obs, exp_e); end
        wb_ready = 1'b0;
        drive_entry(b);
        tick();
        flush = 1'b1;
        drive_entry(c);
        tick();
        flush     = 1'b0;
        mem_valid = 1'b0;
        wb_ready  = 1'b1;
        exp_q.delete();
        checks++; if (wb_valid !== 1'b0 || wb_wreg !== 1'b0 || wb_whilo !== 1'b0) begin
            failures++; $display("FAIL flush_clear: valid=%b wreg=%b whilo=%b want 0", wb_valid, wb_wreg, wb_whilo); end
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b want 1", mem_ready); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_leak: got %b want 0", wb_valid); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_leak2: got %b want 0", wb_valid); end
    endtask

    task automatic test_width();
        logic [127:0] h2;
        h2 = {64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001};
        w_wb_ready  = 1'b1;
        w_mem_valid = 1'b1;
        w_mem_wa    = 5'd17;
        w_mem_wreg  = 1'b1;
        w_mem_dreg  = 64'hFEDC_BA98_7654_3210;
        w_mem_dre   = 8'hA5;
        w_mem_hilo  = 128'h1;
        tick();
        w_mem_hilo = h2;
        checks++; if (w_wb_valid !== 1'b1 || w_wb_hilo !== 128'h1) begin
            failures++; $display("FAIL width_hilo1: valid=%b got %h want 1", w_wb_valid, w_wb_hilo); end
        checks++; if (w_wb_dreg !== 64'hFEDC_BA98_7654_3210 || w_wb_dre !== 8'hA5 || w_wb_wa !== 5'd17) begin
            failures++; $display("FAIL width_fields: dreg=%h dre=%h wa=%0d", w_wb_dreg, w_wb_dre, w_wb_wa); end
        tick();
        w_mem_valid = 1'b0;
        checks++; if (w_wb_hilo !== h2) begin failures++; $display("FAIL width_hilo2: got %h want %h", w_wb_hilo, h2); end
        tick();
        checks++; if (w_wb_valid !== 1'b0 || w_wb_wreg !== 1'b0) begin
            failures++; $display("FAIL width_empty: valid=%b wreg=%b", w_wb_valid, w_wb_wreg); end
    endtask

    initial begin
        mem_valid = 1'b0; mem_wa = '0; mem_wreg = 1'b0; mem_dreg = '0; mem_mreg = 1'b0;
        mem_dre = '0; mem_whilo = 1'b0; mem_hilo = '0; flush = 1'b0; wb_ready = 1'b1;
        w_mem_valid = 1'b0; w_mem_wa = '0; w_mem_wreg = 1'b0; w_mem_dreg = '0; w_mem_mreg = 1'b0;
        w_mem_dre = '0; w_mem_whilo = 1'b0; w_mem_hilo = '0; w_wb_ready = 1'b1;
        cpu_rst_n = 1'b0;
        test_reset();
        test_pass_through();
        test_back_to_back();
        test_bubble();
        test_stall();
        test_flush();
        test_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
